arc4_sched: RTL and testbench

Top-level sequencer for the ARC4 decryption datapath. It accepts a 24-bit key via the `en`/`rdy` handshake and runs the `init`, `ksa` and `prga` engines strictly in that order, issuing each engine its `en` pulse and waiting for its `rdy`. It also owns the single shared S-memory write port, muxing the active engine's address, data and write-enable onto it. A per-phase watchdog aborts a hung engine into a sticky error state.

---
 rtl/arc4_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_arc4_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_sched.sv
// -----------------------------------------------------------------------------
// arc4_sched
//   Top-level sequencer for the ARC4 decryption datapath. It accepts a 24-bit
//   key through the en/rdy handshake, then starts the init, ksa and prga
//   engines strictly in that order. For each engine it waits for that engine's
//   rdy, pulses its en, and waits for rdy again. It also owns the single shared
//   S-memory write port and forwards only the active engine's address, data and
//   write enable onto it. A per-phase watchdog aborts a hung engine into a
//   sticky error state. That state behaves like idle, so a new start is
//   accepted from it.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   en / rdy                 start request / block idle (IDLE or ERR)
//   key / key_q              key input / key latched on accepted start
//   done                     one-cycle pulse after prga completes
//   err                      sticky watchdog abort flag
//   phase                    0 idle/err, 1 init, 2 ksa, 3 prga
//   cycles                   run length counter, saturating
//   <x>_en / <x>_rdy         engine start pulse / engine ready
//   <x>_s_addr/_wrdata/_wren engine S-memory write requests
//   s_addr/s_wrdata/s_wren   shared S-memory write port
// -----------------------------------------------------------------------------
module arc4_sched #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [23:0] key_q,
    output logic        done,
    output logic        err,
    output logic [1:0]  phase,
    output logic [31:0] cycles,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    input  logic [7:0]  init_s_addr,
    input  logic [7:0]  ksa_s_addr,
    input  logic [7:0]  prga_s_addr,
    input  logic [7:0]  init_s_wrdata,
    input  logic [7:0]  ksa_s_wrdata,
    input  logic [7:0]  prga_s_wrdata,
    input  logic        init_s_wren,
    input  logic        ksa_s_wren,
    input  logic        prga_s_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_INIT = 3'd1,
        WAIT_INIT  = 3'd2,
        START_KSA  = 3'd3,
        WAIT_KSA   = 3'd4,
        START_PRGA = 3'd5,
        WAIT_PRGA  = 3'd6,
        ERR        = 3'd7
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic        WDOG_ON   = (TIMEOUT != 0);

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   pcnt_r;
    logic [31:0]   cycles_r;
    logic [23:0]   key_r;
    logic          done_r;
    logic          err_r;
    logic          idle_s;
    logic          accept_s;
    logic          timeout_s;
    logic          start_entry_s;

    assign key_q  = key_r;
    assign cycles = cycles_r;
    assign done   = done_r;
    assign err    = err_r;

    // Idle decode, start acceptance and watchdog expiry.
    always_comb begin
        idle_s    = (state_r == IDLE) || (state_r == ERR);
        accept_s  = idle_s && en;
        timeout_s = WDOG_ON && (pcnt_r == TIMEOUT_W);
        rdy       = idle_s;
    end

    // Next-state logic. A completing engine (rdy high) wins over the watchdog.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, ERR: begin
                if (en) state_s = START_INIT;
                else    state_s = state_r;
            end
            START_INIT: begin
                if (init_rdy)       state_s = WAIT_INIT;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            WAIT_INIT: begin
                if (init_rdy)       state_s = START_KSA;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            START_KSA: begin
                if (ksa_rdy)        state_s = WAIT_KSA;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            WAIT_KSA: begin
                if (ksa_rdy)        state_s = START_PRGA;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            START_PRGA: begin
                if (prga_rdy)       state_s = WAIT_PRGA;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            WAIT_PRGA: begin
                if (prga_rdy)       state_s = IDLE;
                else if (timeout_s) state_s = ERR;
                else                state_s = state_r;
            end
            default: state_s = IDLE;
        endcase
    end

    // Detects a transition into any START_x state. This restarts the phase counter.
    always_comb begin
        if ((state_s != state_r) &&
            ((state_s == START_INIT) || (state_s == START_KSA) || (state_s == START_PRGA)))
            start_entry_s = 1'b1;
        else
            start_entry_s = 1'b0;
    end

    // Engine start pulses: asserted only while the engine is ready in its START state.
    always_comb begin
        init_en = (state_r == START_INIT) && init_rdy;
        ksa_en  = (state_r == START_KSA)  && ksa_rdy;
        prga_en = (state_r == START_PRGA) && prga_rdy;
    end

    // Phase decode from the registered state.
    always_comb begin
        phase = 2'd0;
        case (state_r)
            START_INIT, WAIT_INIT: phase = 2'd1;
            START_KSA,  WAIT_KSA:  phase = 2'd2;
            START_PRGA, WAIT_PRGA: phase = 2'd3;
            default:               phase = 2'd0;
        endcase
    end

    // Shared S-port mux. Writes from engines that are not selected are dropped.
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (state_r)
            START_INIT, WAIT_INIT: begin
                s_addr   = init_s_addr;
                s_wrdata = init_s_wrdata;
                s_wren   = init_s_wren;
            end
            START_KSA, WAIT_KSA: begin
                s_addr   = ksa_s_addr;
                s_wrdata = ksa_s_wrdata;
                s_wren   = ksa_s_wren;
            end
            START_PRGA, WAIT_PRGA: begin
                s_addr   = prga_s_addr;
                s_wrdata = prga_s_wrdata;
                s_wren   = prga_s_wren;
            end
            default: begin
                s_addr   = 8'd0;
                s_wrdata = 8'd0;
                s_wren   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Watchdog phase counter: cleared on START entry, counts while a phase runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pcnt_r <= 16'd0;
        else if (start_entry_s) pcnt_r <= 16'd0;
        else if (!idle_s)       pcnt_r <= pcnt_r + 16'd1;
        else                    pcnt_r <= pcnt_r;
    end

    // Run length counter. It starts at 1 on acceptance and saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     cycles_r <= 32'd0;
        else if (accept_s)                              cycles_r <= 32'd1;
        else if (!idle_s && (cycles_r != 32'hFFFF_FFFF)) cycles_r <= cycles_r + 32'd1;
        else                                            cycles_r <= cycles_r;
    end

    // Key latch on accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        key_r <= 24'd0;
        else if (accept_s) key_r <= key;
        else               key_r <= key_r;
    end

    // done pulses for the first IDLE cycle after prga completes. err is set while in ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= (state_r == WAIT_PRGA) && prga_rdy;
            err_r  <= (state_s == ERR);
        end
    end

endmodule

// File: tb/tb_arc4_sched.sv
// -----------------------------------------------------------------------------
// tb_arc4_sched
//   Scoreboarded bench for arc4_sched. The stimulus tasks push the expected
//   engine-start, done and err events, each with the cycle it must appear in.
//   A monitor pops and compares one entry whenever the DUT raises one of those
//   outputs. Engine stubs have programmable latency and drive fixed S-port
//   requests so the mux can be observed.
// -----------------------------------------------------------------------------
module tb_arc4_sched;

    localparam int K_INIT = 1, K_KSA = 2, K_PRGA = 3, K_DONE = 4, K_ERR = 5;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] key = 24'd0;
    logic        rdy, done, err;
    logic [23:0] key_q;
    logic [1:0]  phase;
    logic [31:0] cycles;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    int  init_cnt = 0, ksa_cnt = 0, prga_cnt = 0;
    int  init_lat = 4, ksa_lat = 6, prga_lat = 8;
    bit  init_hold = 1'b0;
    bit  stub_clr = 1'b0;
    bit  prev_err = 1'b0;

    arc4_sched #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_q(key_q),
        .done(done), .err(err), .phase(phase), .cycles(cycles),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_s_addr(8'h11), .ksa_s_addr(8'h22), .prga_s_addr(8'h33),
        .init_s_wrdata(8'hA1), .ksa_s_wrdata(8'hB2), .prga_s_wrdata(8'hC3),
        .init_s_wren(1'b1), .ksa_s_wren(1'b1), .prga_s_wren(1'b1),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    always #5 clk = ~clk;

    // Free-running cycle index.
    always @(posedge clk) cyc <= cyc + 1;

    // Engine stubs: rdy drops for <lat> cycles after each en pulse.
    always @(posedge clk) begin
        if (!rst_n || stub_clr) begin
            init_cnt <= 0; ksa_cnt <= 0; prga_cnt <= 0;
        end else begin
            if (init_en) init_cnt <= init_lat; else if (init_cnt != 0) init_cnt <= init_cnt - 1;
            if (ksa_en)  ksa_cnt  <= ksa_lat;  else if (ksa_cnt  != 0) ksa_cnt  <= ksa_cnt - 1;
            if (prga_en) prga_cnt <= prga_lat; else if (prga_cnt != 0) prga_cnt <= prga_cnt - 1;
        end
    end
    assign init_rdy = (init_cnt == 0) && !init_hold;
    assign ksa_rdy  = (ksa_cnt == 0);
    assign prga_rdy = (prga_cnt == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.cyc = c; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected actual kind=%0d cycle=%0d required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
                failures++;
                $display("FAIL event actual kind=%0d cycle=%0d data=%0d required kind=%0d cycle=%0d data=%0d",
                         kind, cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (init_en) observe(K_INIT, 32'd0);
        if (ksa_en)  observe(K_KSA, 32'd0);
        if (prga_en) observe(K_PRGA, 32'd0);
        if (done)    observe(K_DONE, cycles);
        if (err && !prev_err) observe(K_ERR, 32'd0);
        prev_err = err;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stubs();
        stub_clr = 1'b1;
        next_cycle();
        stub_clr = 1'b0;
    endtask

    // Full run with latencies 4/6/8, with per-cycle rdy, err and S-port checks.
    task automatic run_normal(input logic [23:0] k);
        int base;
        logic [7:0] ea;
        next_cycle();
        base = cyc;
        push(K_INIT, base + 1, 32'd0);
        push(K_KSA,  base + 7, 32'd0);
        push(K_PRGA, base + 15, 32'd0);
        push(K_DONE, base + 25, 32'd25);
        en = 1'b1; key = k;
        for (int i = 0; i <= 27; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) begin en = 1'b0; key = 24'd0; end
            @(negedge clk);
            chk("rdy", {31'd0, rdy}, (i >= 1 && i <= 24) ? 32'd0 : 32'd1);
            if (i >= 1 && i <= 6)       ea = 8'h11;
            else if (i >= 7 && i <= 14) ea = 8'h22;
            else if (i >= 15 && i <= 24) ea = 8'h33;
            else                        ea = 8'h00;
            chk("s_addr", {24'd0, s_addr}, {24'd0, ea});
            chk("s_wren", {31'd0, s_wren}, (ea != 8'h00) ? 32'd1 : 32'd0);
            if (i == 1)  chk("err_cleared", {31'd0, err}, 32'd0);
            if (i == 10) chk("s_wrdata_ksa", {24'd0, s_wrdata}, 32'h0000_00B2);
            if (i == 25) chk("key_q", {8'd0, key_q}, {8'd0, k});
        end
    endtask

    initial begin
        // Reset values while rst_n is low.
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_phase", {30'd0, phase}, 32'd0);
        chk("rst_key_q", {8'd0, key_q}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
        chk("rst_init_en", {31'd0, init_en}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // Normal run combined with mux isolation.
        run_normal(24'h010203);

        // Timeout: ksa never returns ready, so the watchdog fires 16 cycles into ksa.
        begin
            int base;
            ksa_lat = 1000;
            next_cycle();
            base = cyc;
            push(K_INIT, base + 1, 32'd0);
            push(K_KSA,  base + 7, 32'd0);
            push(K_ERR,  base + 24, 32'd0);
            en = 1'b1; key = 24'h0A0B0C;
            for (int i = 1; i <= 27; i++) begin
                next_cycle();
                en = 1'b0;
                @(negedge clk);
                if (i == 23) chk("to_rdy_before", {31'd0, rdy}, 32'd0);
                if (i == 24) begin
                    chk("to_err", {31'd0, err}, 32'd1);
                    chk("to_rdy", {31'd0, rdy}, 32'd1);
                    chk("to_phase", {30'd0, phase}, 32'd0);
                    chk("to_s_wren", {31'd0, s_wren}, 32'd0);
                end
                if (i == 27) chk("to_err_sticky", {31'd0, err}, 32'd1);
            end
        end

        // Restart from ERR.
        ksa_lat = 6;
        clear_stubs();
        run_normal(24'h010203);

        // Engine not ready: init_rdy low in cycles 1-5, so init_en appears in cycle 6.
        begin
            int base;
            next_cycle();
            base = cyc;
            push(K_INIT, base + 6, 32'd0);
            push(K_KSA,  base + 12, 32'd0);
            push(K_PRGA, base + 20, 32'd0);
            push(K_DONE, base + 30, 32'd30);
            en = 1'b1; key = 24'h445566; init_hold = 1'b1;
            for (int i = 1; i <= 32; i++) begin
                next_cycle();
                en = 1'b0;
                if (i == 6) init_hold = 1'b0;
                @(negedge clk);
                if (i == 3) chk("nr_phase", {30'd0, phase}, 32'd1);
            end
        end

        // Ignored start during WAIT_KSA, then reset during WAIT_PRGA.
        begin
            int base;
            next_cycle();
            base = cyc;
            push(K_INIT, base + 1, 32'd0);
            push(K_KSA,  base + 7, 32'd0);
            push(K_PRGA, base + 15, 32'd0);
            en = 1'b1; key = 24'h010203;
            for (int i = 1; i <= 30; i++) begin
                next_cycle();
                if (i == 1)  en = 1'b0;
                if (i == 10) begin en = 1'b1; key = 24'hABCDEF; end
                if (i == 11) begin en = 1'b0; key = 24'd0; end
                if (i == 20) rst_n = 1'b0;
                if (i == 23) rst_n = 1'b1;
                @(negedge clk);
                if (i == 11) chk("ign_phase", {30'd0, phase}, 32'd2);
                if (i == 19) begin
                    chk("ign_key_q", {8'd0, key_q}, 32'h0001_0203);
                    chk("ign_cycles", cycles, 32'd19);
                end
                if (i == 20) begin
                    chk("mr_rdy", {31'd0, rdy}, 32'd1);
                    chk("mr_phase", {30'd0, phase}, 32'd0);
                    chk("mr_key_q", {8'd0, key_q}, 32'd0);
                    chk("mr_cycles", cycles, 32'd0);
                    chk("mr_done", {31'd0, done}, 32'd0);
                    chk("mr_err", {31'd0, err}, 32'd0);
                    chk("mr_s_wren", {31'd0, s_wren}, 32'd0);
                    chk("mr_s_addr", {24'd0, s_addr}, 32'd0);
                end
                if (i == 26) chk("mr_idle_after", {31'd0, rdy}, 32'd1);
            end
        end

        repeat (3) next_cycle();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
